// File: rtl/temp_conv_pipe.sv
// TMP36-class ADC code to Celsius/Fahrenheit (x10) converter: three-stage valid/ready
// pipeline with sticky per-channel alarms; per-channel min/max tracking when TEMP_MINMAX_EN is defined.
module temp_conv_pipe #(
    parameter int ADC_W     = 10,
    parameter int VREF_MV   = 5000,
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int ALARM_X10 = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADC_W-1:0]  in_code,
    input  logic [CH_W-1:0]   in_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_chan,
    output logic [15:0]       out_c_x10,
    output logic [15:0]       out_f_x10,
    output logic [NUM_CH-1:0] alarm,
    input  logic [NUM_CH-1:0] alarm_clr,
    input  logic [CH_W-1:0]   rd_chan,
    output logic [15:0]       rd_min_x10,
    output logic [15:0]       rd_max_x10
);

    localparam int MV_W   = 13;
    localparam int PROD_W = ADC_W + MV_W;
    localparam logic signed [15:0] ALARM_S  = 16'(ALARM_X10);
    localparam logic signed [15:0] MIN_INIT = 16'sh7FFF;
    localparam logic signed [15:0] MAX_INIT = 16'sh8000;

    genvar gi;

    logic                     advance;
    logic                     s1_valid_reg;
    logic [MV_W-1:0]          s1_mv_reg;
    logic [CH_W-1:0]          s1_chan_reg;
    logic                     s2_valid_reg;
    logic signed [15:0]       s2_c_reg;
    logic [CH_W-1:0]          s2_chan_reg;
    logic                     out_valid_reg;
    logic [CH_W-1:0]          out_chan_reg;
    logic signed [15:0]       out_c_reg;
    logic signed [15:0]       out_f_reg;
    logic [NUM_CH-1:0]        alarm_reg;
    logic [NUM_CH-1:0]        alarm_set;
    logic [NUM_CH-1:0]        alarm_next;

    // Every stage moves together; a stalled output freezes the whole pipe.
    assign advance  = !out_valid_reg || out_ready;
    assign in_ready = advance;

    // S1: code -> millivolts, full-width product then truncating shift.
    logic [PROD_W-1:0] s1_prod;
    logic [MV_W-1:0]   s1_mv_next;
    assign s1_prod    = PROD_W'(in_code) * PROD_W'(VREF_MV);
    assign s1_mv_next = MV_W'(s1_prod >> ADC_W);

    // S2: remove the 500 mV sensor offset; result is tenths of a degree C.
    logic signed [15:0] s2_c_next;
    assign s2_c_next = $signed({{(16-MV_W){1'b0}}, s1_mv_reg}) - 16'sd500;

    // S3: Fahrenheit via signed divide, which truncates toward zero.
    logic signed [19:0] s3_c_ext;
    logic signed [19:0] s3_c9;
    logic signed [19:0] s3_q;
    logic signed [15:0] s3_f;
    logic               s3_load;
    assign s3_c_ext = {{4{s2_c_reg[15]}}, s2_c_reg};
    assign s3_c9    = s3_c_ext * 20'sd9;
    assign s3_q     = s3_c9 / 20'sd5;
    assign s3_f     = 16'(s3_q + 20'sd320);
    assign s3_load  = advance && s2_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_mv_reg     <= '0;
            s1_chan_reg   <= '0;
            s2_valid_reg  <= 1'b0;
            s2_c_reg      <= '0;
            s2_chan_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_chan_reg  <= '0;
            out_c_reg     <= '0;
            out_f_reg     <= '0;
        end else if (advance) begin
            s1_valid_reg  <= in_valid;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            if (in_valid) begin
                s1_mv_reg   <= s1_mv_next;
                s1_chan_reg <= in_chan;
            end
            if (s1_valid_reg) begin
                s2_c_reg    <= s2_c_next;
                s2_chan_reg <= s1_chan_reg;
            end
            if (s2_valid_reg) begin
                out_chan_reg <= s2_chan_reg;
                out_c_reg    <= s2_c_reg;
                out_f_reg    <= s3_f;
            end
        end
    end

    // Channel tags >= NUM_CH match no generated index, so they never set an alarm.
    for (gi = 0; gi < NUM_CH; gi++) begin : g_alarm
        assign alarm_set[gi] = s3_load && (s2_chan_reg == CH_W'(gi)) && (s2_c_reg >= ALARM_S);
    end

    // Set dominates a same-cycle clear.
    assign alarm_next = (alarm_reg & ~alarm_clr) | alarm_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_reg <= '0;
        end else begin
            alarm_reg <= alarm_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_chan  = out_chan_reg;
    assign out_c_x10 = out_c_reg;
    assign out_f_x10 = out_f_reg;
    assign alarm     = alarm_reg;

`ifdef TEMP_MINMAX_EN
    logic signed [15:0] min_rd [2**CH_W];
    logic signed [15:0] max_rd [2**CH_W];

    // Unused tag codes read back the initial values.
    for (gi = 0; gi < 2**CH_W; gi++) begin : g_mm
        if (gi < NUM_CH) begin : g_ch
            logic               hit;
            logic signed [15:0] min_reg;
            logic signed [15:0] max_reg;
            logic signed [15:0] min_base;
            logic signed [15:0] max_base;
            logic signed [15:0] min_next;
            logic signed [15:0] max_next;

            // A clear restarts tracking; a result arriving on the same edge is its first entry.
            assign hit      = s3_load && (s2_chan_reg == CH_W'(gi));
            assign min_base = alarm_clr[gi] ? MIN_INIT : min_reg;
            assign max_base = alarm_clr[gi] ? MAX_INIT : max_reg;
            assign min_next = (hit && (s2_c_reg < min_base)) ? s2_c_reg : min_base;
            assign max_next = (hit && (s2_c_reg > max_base)) ? s2_c_reg : max_base;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    min_reg <= MIN_INIT;
                    max_reg <= MAX_INIT;
                end else begin
                    min_reg <= min_next;
                    max_reg <= max_next;
                end
            end

            assign min_rd[gi] = min_reg;
            assign max_rd[gi] = max_reg;
        end else begin : g_pad
            assign min_rd[gi] = MIN_INIT;
            assign max_rd[gi] = MAX_INIT;
        end
    end

    assign rd_min_x10 = min_rd[rd_chan];
    assign rd_max_x10 = max_rd[rd_chan];
`else
    logic unused_rd;
    assign unused_rd  = ^rd_chan;
    assign rd_min_x10 = '0;
    assign rd_max_x10 = '0;
`endif

endmodule

// File: tb/tb_temp_conv_pipe.sv
// Self-checking bench for temp_conv_pipe: vector table, hand-written corner sequences,
// and randomized traffic with back-pressure checked against an arithmetic reference model.
module tb_temp_conv_pipe;

    localparam int ADC_W     = 10;
    localparam int VREF_MV   = 5000;
    localparam int NUM_CH    = 4;
    localparam int CH_W      = 2;
    localparam int ALARM_X10 = 400;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADC_W-1:0]  in_code;
    logic [CH_W-1:0]   in_chan;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_chan;
    logic [15:0]       out_c_x10;
    logic [15:0]       out_f_x10;
    logic [NUM_CH-1:0] alarm;
    logic [NUM_CH-1:0] alarm_clr;
    logic [CH_W-1:0]   rd_chan;
    logic [15:0]       rd_min_x10;
    logic [15:0]       rd_max_x10;

    temp_conv_pipe #(
        .ADC_W(ADC_W), .VREF_MV(VREF_MV), .NUM_CH(NUM_CH), .CH_W(CH_W), .ALARM_X10(ALARM_X10)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_chan(in_chan),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_c_x10(out_c_x10), .out_f_x10(out_f_x10),
        .alarm(alarm), .alarm_clr(alarm_clr),
        .rd_chan(rd_chan), .rd_min_x10(rd_min_x10), .rd_max_x10(rd_max_x10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int code;
        int chan;
        int c;
        int f;
    } vec_t;

    typedef struct {
        int chan;
        int c;
        int f;
        int acc;
        bit seen;
    } exp_t;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    exp_t              sb_q[$];
    int                drv_c;
    int                drv_f;
    bit                lat_chk  = 1'b0;
    bit                rnd_done = 1'b0;
    logic [NUM_CH-1:0] model_alarm;
    int                model_min [NUM_CH];
    int                model_max [NUM_CH];
    vec_t              tbl [6];

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference conversion straight from the sensor/ADC arithmetic.
    function automatic int ref_c(input int code);
        return (code * VREF_MV) / (1 << ADC_W) - 500;
    endfunction

    function automatic int ref_f(input int c);
        return (c * 9) / 5 + 320;
    endfunction

    task automatic model_clear(input logic [NUM_CH-1:0] m);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (m[ch]) begin
                model_alarm[ch] = 1'b0;
                model_min[ch]   = 32767;
                model_max[ch]   = -32768;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Scoreboard: every visible output is compared with the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
            end else begin
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        chk("out_chan", int'(out_chan), sb_q[0].chan);
                        chk("out_c", int'($signed(out_c_x10)), sb_q[0].c);
                        chk("out_f", int'($signed(out_f_x10)), sb_q[0].f);
                        if (lat_chk && !sb_q[0].seen) chk("latency", cyc - sb_q[0].acc, 3);
                        sb_q[0].seen = 1'b1;
                        if (out_ready) void'(sb_q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    e.chan = int'(in_chan);
                    e.c    = drv_c;
                    e.f    = drv_f;
                    e.acc  = cyc;
                    e.seen = 1'b0;
                    sb_q.push_back(e);
                    if (e.chan < NUM_CH) begin
                        if (e.c >= ALARM_X10) model_alarm[e.chan] = 1'b1;
                        if (e.c < model_min[e.chan]) model_min[e.chan] = e.c;
                        if (e.c > model_max[e.chan]) model_max[e.chan] = e.c;
                    end
                end
            end
        end
    end

    task automatic send(input int code, input int chan, input int ec, input int ef);
        bit ok;
        ok       = 1'b0;
        in_code  = ADC_W'(code);
        in_chan  = CH_W'(chan);
        drv_c    = ec;
        drv_f    = ef;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok        = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (!out_valid && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic pulse_clr(input logic [NUM_CH-1:0] m);
        alarm_clr = m;
        @(posedge clk);
        #1;
        alarm_clr = '0;
        model_clear(m);
    endtask

    initial begin
        tbl[0] = '{code: 154,  chan: 0, c: 251,  f: 771};
        tbl[1] = '{code: 0,    chan: 0, c: -500, f: -580};
        tbl[2] = '{code: 1023, chan: 0, c: 4495, f: 8411};
        tbl[3] = '{code: 102,  chan: 1, c: -2,   f: 317};
        tbl[4] = '{code: 100,  chan: 1, c: -12,  f: 299};
        tbl[5] = '{code: 512,  chan: 3, c: 2000, f: 3920};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_chan   = '0;
        out_ready = 1'b1;
        alarm_clr = '0;
        rd_chan   = '0;
        model_clear('1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_out_c", int'(out_c_x10), 0);
        chk("rst_out_f", int'(out_f_x10), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", int'(in_ready), 1);

        // Back-to-back vectors, no back-pressure: latency must be exactly 3.
        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) send(tbl[i].code, tbl[i].chan, tbl[i].c, tbl[i].f);
        drain();
        chk("alarm_after_table", int'(alarm), 4'b1001);
        pulse_clr('1);
        chk("alarm_cleared", int'(alarm), 0);

        // Stall the output while four samples are offered.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(110 + 10 * i, 1, ref_c(110 + 10 * i), ref_f(ref_c(110 + 10 * i)));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_out_valid", int'(out_valid), 1);
                out_ready = 1'b1;
            end
        join
        drain();

        // Alarm threshold, set-over-clear priority, clear.
        lat_chk = 1'b1;
        send(184, 2, 398, 1036);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("alarm_below_thr", int'(alarm), 0);
        send(185, 2, 403, 1045);
        @(posedge clk);
        #1;
        chk("alarm_not_yet", int'(alarm), 0);
        @(posedge clk);
        #1;
        chk("alarm_set", int'(alarm), 4'b0100);
        drain();
        pulse_clr(4'b0100);
        chk("alarm_clr_alone", int'(alarm), 0);
        send(185, 2, 403, 1045);
        @(posedge clk);
        #1;
        alarm_clr = 4'b0100;
        @(posedge clk);
        #1;
        alarm_clr = '0;
        chk("alarm_set_wins", int'(alarm), 4'b0100);
        drain();
        pulse_clr(4'b0100);
        chk("alarm_clr_later", int'(alarm), 0);

        // Asynchronous reset with samples in flight.
        send(185, 2, 403, 1045);
        send(154, 1, 251, 771);
        send(0, 1, -500, -580);
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_alarm", int'(alarm), 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_alarm", int'(alarm), 0);
        chk("async_rst_c", int'(out_c_x10), 0);
        chk("async_rst_f", int'(out_f_x10), 0);
        model_clear('1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(102, 1, -2, 317);
        drain();
        chk("alarm_neg_temp", int'(alarm), 0);

        // Min/max tracking on channel 3; channel 0 untouched since reset.
        send(154, 3, 251, 771);
        send(0, 3, -500, -580);
        send(1023, 3, 4495, 8411);
        drain();
        rd_chan = 2'd3;
        #1;
`ifdef TEMP_MINMAX_EN
        chk("rd_min_ch3", int'($signed(rd_min_x10)), -500);
        chk("rd_max_ch3", int'($signed(rd_max_x10)), 4495);
        rd_chan = 2'd0;
        #1;
        chk("rd_min_ch0", int'($signed(rd_min_x10)), 32767);
        chk("rd_max_ch0", int'($signed(rd_max_x10)), -32768);
`else
        chk("rd_min_tied", int'(rd_min_x10), 0);
        chk("rd_max_tied", int'(rd_max_x10), 0);
`endif
        chk("alarm_ch3", int'(alarm), 4'b1000);
        pulse_clr('1);

        // Random traffic with random back-pressure.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int code;
                    int ch;
                    int c;
                    code = (i % 17 == 0) ? 1023 : ((i % 19 == 0) ? 0 : int'($urandom_range(0, 1023)));
                    ch   = int'($urandom_range(0, NUM_CH - 1));
                    c    = ref_c(code);
                    send(code, ch, c, ref_f(c));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("alarm_random", int'(alarm), int'(model_alarm));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rd_chan = CH_W'(ch);
            #1;
`ifdef TEMP_MINMAX_EN
            chk("rd_min_random", int'($signed(rd_min_x10)), model_min[ch]);
            chk("rd_max_random", int'($signed(rd_max_x10)), model_max[ch]);
`else
            chk("rd_min_tied_random", int'(rd_min_x10), 0);
`endif
        end
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/temp_conv_pipe.md
Name: temp_conv_pipe

Overview:
Multi-channel, pipelined ADC-code to temperature converter for TMP36-class analog sensors (10 mV/°C, 500 mV offset).
- Accepts one ADC sample per cycle, tagged with a channel number, over a valid/ready handshake.
- Produces signed fixed-point Celsius and Fahrenheit in tenths of a degree.
- Keeps a sticky per-channel over-temperature alarm.
- Sits between the ADC sampling front-end and the display/UART formatting logic.

Parameters:
- ADC_W, 10, ADC code width in bits (full scale = 2^ADC_W).
- VREF_MV, 5000, ADC reference voltage in millivolts, range 1..8191.
- NUM_CH, 4, number of sensor channels, range 1..16.
- CH_W, 2, channel tag width; must satisfy 2^CH_W >= NUM_CH.
- ALARM_X10, 400, alarm threshold in tenths of °C (signed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts sample this cycle.
- in_code  in  ADC_W  raw ADC code, unsigned.
- in_chan  in  CH_W  channel tag of sample.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_chan  out  CH_W  channel tag of result.
- out_c_x10  out  16  Celsius ×10, signed two's complement.
- out_f_x10  out  16  Fahrenheit ×10, signed two's complement.
- alarm  out  NUM_CH  sticky per-channel over-temperature flags.
- alarm_clr  in  NUM_CH  per-channel alarm clear strobes.
- rd_chan  in  CH_W  min/max read select (optional feature).
- rd_min_x10  out  16  minimum Celsius ×10 seen on rd_chan (optional feature).
- rd_max_x10  out  16  maximum Celsius ×10 seen on rd_chan (optional feature).

Behaviour:

Reset:
- rst asserted at any time clears all pipeline valid bits, out_valid, alarm, and all data outputs to 0, immediately (asynchronous).
- A sample in flight when rst asserts is discarded.

Handshake:
- Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
- Pipeline advance is advance = !out_valid || out_ready. in_ready = advance, combinational.
- When advance is 0, every stage holds; out_* stay stable while out_valid && !out_ready.
- in_chan values >= NUM_CH are accepted and converted; they never touch alarm or min/max state.

Pipeline: three stages. Latency is exactly 3 cycles from accept to out_valid with no back-pressure. Throughput is 1 sample per cycle.
- S1: mv = (in_code * VREF_MV) >> ADC_W. Unsigned, full-width product of ADC_W+13 bits, truncating.
- S2: c = mv - 500, signed 16-bit.
- S3: f = (c*9)/5 + 320. The signed division truncates toward zero. Intermediate c*9 is at least 20 bits signed.

Alarm:
- Evaluated when a result leaves S3 into the output register: if c >= ALARM_X10 and chan < NUM_CH, set alarm[chan].
- alarm_clr[i] clears alarm[i] on the next edge.
- Simultaneous set and clear on the same channel: set wins.

Optional Feature:
Macro: TEMP_MINMAX_EN.
- Defined: per-channel signed min/max registers.
  - Reset values: min = 16'sh7FFF, max = 16'sh8000.
  - Updated on the same event as the alarm (result entering the output register, chan < NUM_CH).
  - alarm_clr[i] also reinitialises min[i]/max[i] to the reset values.
  - rd_min_x10/rd_max_x10 are a combinational read of channel rd_chan. rd_chan >= NUM_CH reads the reset values.
- Undefined: no min/max storage; rd_min_x10 and rd_max_x10 are tied to 0.

Test Plan:
1. Default params; chan 0 codes 154, 0, 1023 back-to-back, out_ready=1 -> outputs on cycles 3, 4, 5 after first accept:
   - 154 -> (c, f) = (251, 771)
   - 0 -> (c, f) = (-500, -580)
   - 1023 -> (c, f) = (4495, 8411)
2. Code 102, chan 1 -> c = -2, f = 317 (truncation toward zero); alarm = 0.
3. out_ready=0 for 5 cycles with 4 samples offered -> in_ready drops once the pipe is full; out_* stable; no sample lost or duplicated after out_ready=1.
4. Code 184 (mv=898, c=398) then 185 (mv=903, c=403) on chan 2 -> alarm[2] rises only after the second result; same-cycle alarm set and alarm_clr[2] -> alarm[2] stays 1; later alarm_clr[2] alone -> 0.
5. Assert rst mid-stream with 2 samples in flight -> out_valid=0 and alarm=0 immediately; after release, the first new sample emerges at latency 3 with no stale results.
6. TEMP_MINMAX_EN defined; chan 3 codes 154, 0, 1023 -> rd_chan=3 reads min = -500, max = 4495; rd_chan=0 reads 32767 / -32768.
